// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states, register
// word offsets within the 16-byte window, and ICAUSE/ICTRL field positions.
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ENTER  = 2'd2,
        ST_KERNEL = 2'd3
    } state_t;

    // Word index (addr[3:2]) of each register
    localparam logic [1:0] REG_IMASK  = 2'd0;
    localparam logic [1:0] REG_IPEND  = 2'd1;
    localparam logic [1:0] REG_ICAUSE = 2'd2;
    localparam logic [1:0] REG_ICTRL  = 2'd3;

    localparam int ICAUSE_VLD_BIT = 31;
    localparam int ICAUSE_ID_W    = 4;
    localparam int ICTRL_GIE_BIT  = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder over the eligible request vector.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [3:0]   id
);

    always_comb begin
        vld = 1'b0;
        id  = 4'd0;
        // Walk downwards so the lowest set index is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                id  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt arbiter: pending/mask/GIE registers, one-in-service FSM.
// Optional macro IRQ_LEVEL_EN makes IPEND follow the source levels instead of latching edges.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0020
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               ker,
    input  logic               irq_take,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               mem_read,
    input  logic               mem_write,
    output logic [31:0]        rdata,
    output logic               hit,
    output logic               IRQ
);

    state_t                   state, state_nxt;
    logic [NUM_SRC-1:0]       imask, imask_nxt;
    logic [NUM_SRC-1:0]       ipend, ipend_nxt;
    logic                     gie, gie_nxt;
    logic                     cause_vld;
    logic [ICAUSE_ID_W-1:0]   cause_id;
    logic [NUM_SRC-1:0]       elig, elig_nxt;
    logic [NUM_SRC-1:0]       take_clr, w1c;
    logic                     win_vld, take, wr_en;
    logic [3:0]               win_id;
    logic [1:0]               reg_sel;
    logic                     unused_bits;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel     = addr[3:2];
    assign wr_en       = mem_write & hit;
    assign unused_bits = ^{addr[1:0], wdata};

    assign elig = gie ? (ipend & imask) : '0;

    irq_prio_enc #(.N(NUM_SRC)) u_prio (
        .req (elig),
        .vld (win_vld),
        .id  (win_id)
    );

    assign take = (state == ST_REQ) & irq_take & win_vld;

    always_comb begin
        take_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            take_clr[i] = take && (win_id == 4'(i));
        end
    end

    assign w1c       = (wr_en && reg_sel == REG_IPEND) ? wdata[NUM_SRC-1:0] : '0;
    assign imask_nxt = (wr_en && reg_sel == REG_IMASK) ? wdata[NUM_SRC-1:0] : imask;
    assign gie_nxt   = (wr_en && reg_sel == REG_ICTRL) ? wdata[ICTRL_GIE_BIT] : gie;

`ifdef IRQ_LEVEL_EN
    assign ipend     = src_irq;
    assign ipend_nxt = src_irq;
`else
    logic [NUM_SRC-1:0] src_d;

    // A fresh rising edge wins over both take-clear and software W1C
    assign ipend_nxt = (ipend & ~(take_clr | w1c)) | (src_irq & ~src_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d <= '0;
            ipend <= '0;
        end else begin
            src_d <= src_irq;
            ipend <= ipend_nxt;
        end
    end
`endif

    // REQ falls back as soon as the register updates leave nothing eligible
    assign elig_nxt = gie_nxt ? (ipend_nxt & imask_nxt) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (|elig && !ker) state_nxt = ST_REQ;
            ST_REQ:    if (take) state_nxt = ST_ENTER;
                       else if (elig_nxt == '0) state_nxt = ST_IDLE;
            ST_ENTER:  if (ker) state_nxt = ST_KERNEL;
            ST_KERNEL: if (!ker) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            imask     <= '0;
            gie       <= 1'b0;
            cause_vld <= 1'b0;
            cause_id  <= '0;
        end else begin
            state <= state_nxt;
            imask <= imask_nxt;
            gie   <= gie_nxt;
            if (take) begin
                cause_vld <= 1'b1;
                cause_id  <= win_id;
            end
        end
    end

    assign IRQ = (state == ST_REQ) & ~ker;

    always_comb begin
        rdata = '0;
        if (hit && mem_read) begin
            case (reg_sel)
                REG_IMASK:  rdata[NUM_SRC-1:0] = imask;
                REG_IPEND:  rdata[NUM_SRC-1:0] = ipend;
                REG_ICAUSE: begin
                    rdata[ICAUSE_VLD_BIT]     = cause_vld;
                    rdata[ICAUSE_ID_W-1:0]    = cause_id;
                end
                REG_ICTRL:  rdata[ICTRL_GIE_BIT] = gie;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_irq_arbiter;

    localparam logic [31:0] BASE = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        ker, irq_take, mem_read, mem_write;
    logic [31:0] addr, wdata, rdata;
    logic        hit, IRQ;

    irq_arbiter #(.NUM_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_irq   (src_irq),
        .ker       (ker),
        .irq_take  (irq_take),
        .addr      (addr),
        .wdata     (wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .rdata     (rdata),
        .hit       (hit),
        .IRQ       (IRQ)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: register contents plus where the core is in the service cycle
    // (0 waiting, 1 requesting, 2 vectored awaiting kernel, 3 in handler).
    bit [3:0]  m_mask, m_pend, m_src_d;
    bit        m_gie;
    bit [31:0] m_cause;
    int        m_phase;
    logic [31:0] obs_rdata;
    logic        obs_irq;

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd16);
    endfunction

    task automatic model_reset();
        m_mask = 0; m_pend = 0; m_src_d = 0; m_gie = 0; m_cause = 0; m_phase = 0;
    endtask

    task automatic cycle(input logic [3:0] s, input logic k, input logic t,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic rd, input logic wr);
        bit [3:0]  elig, elig_new, clr;
        bit [31:0] exp_rd;
        int        win, off;
        bit        tk;
        @(negedge clk);
        src_irq = s; ker = k; irq_take = t; addr = a; wdata = wd;
        mem_read = rd; mem_write = wr;
        #1;
        elig = m_gie ? (m_pend & m_mask) : 4'b0;
        win = -1;
        for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
        off = in_win(a) ? int'(a - BASE) / 4 : -1;
        exp_rd = 0;
        if (rd) begin
            case (off)
                0: exp_rd = {28'b0, m_mask};
                1: exp_rd = {28'b0, m_pend};
                2: exp_rd = m_cause;
                3: exp_rd = {31'b0, m_gie};
                default: exp_rd = 0;
            endcase
        end
        obs_rdata = rdata;
        obs_irq   = IRQ;
        check("hit", {31'b0, hit}, {31'b0, in_win(a)});
        check("irq", {31'b0, IRQ}, {31'b0, (m_phase == 1) && !k});
        check("rdata", rdata, exp_rd);
        // Advance the model to what the registers must hold after this edge
        clr = (wr && off == 1) ? wd[3:0] : 4'b0;
        tk  = (m_phase == 1) && t && (win >= 0);
        if (tk) begin
            clr[win] = 1'b1;
            m_cause  = 32'h8000_0000 + 32'(win);
        end
        for (int i = 0; i < 4; i++) begin
            if (s[i] && !m_src_d[i]) m_pend[i] = 1'b1;
            else if (clr[i])         m_pend[i] = 1'b0;
        end
        m_src_d = s;
        if (wr && off == 0) m_mask = wd[3:0];
        if (wr && off == 3) m_gie  = wd[0];
        elig_new = m_gie ? (m_pend & m_mask) : 4'b0;
        case (m_phase)
            0: if (elig != 0 && !k) m_phase = 1;
            1: if (tk) m_phase = 2; else if (elig_new == 0) m_phase = 0;
            2: if (k) m_phase = 3;
            default: if (!k) m_phase = 0;
        endcase
        @(posedge clk);
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        cycle(4'b0, 1'b0, 1'b0, BASE + 32'(off), d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input int off);
        cycle(4'b0, 1'b0, 1'b0, BASE + 32'(off), 32'b0, 1'b1, 1'b0);
    endtask

    task automatic nop(input logic k);
        cycle(4'b0, k, 1'b0, 32'b0, 32'b0, 1'b0, 1'b0);
    endtask

    task automatic take_cycle();
        cycle(4'b0, 1'b0, 1'b1, 32'b0, 32'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] s, input logic k);
        cycle(s, k, 1'b0, 32'b0, 32'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; src_irq = 0; ker = 0; irq_take = 0;
        addr = 0; wdata = 0; mem_read = 0; mem_write = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_irq", {31'b0, IRQ}, 32'd0);
        check("reset_hit", {31'b0, hit}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rd_reg(4 * r);
            check("reset_reg", obs_rdata, 32'd0);
        end

        // Basic service
        wr_reg(0, 32'h6);
        wr_reg(12, 32'h1);
        pulse(4'b0100, 1'b0);
        nop(1'b0);
        check("basic_irq_lat", {31'b0, obs_irq}, 32'd0);
        nop(1'b0);
        check("basic_irq", {31'b0, obs_irq}, 32'd1);
        take_cycle();
        rd_reg(8);
        check("basic_cause", obs_rdata, 32'h8000_0002);
        check("basic_irq_drop", {31'b0, obs_irq}, 32'd0);
        rd_reg(4);
        check("basic_pend", obs_rdata, 32'd0);
        nop(1'b1);
        nop(1'b0);

        // Priority
        wr_reg(0, 32'hF);
        pulse(4'b1010, 1'b0);
        nop(1'b0);
        take_cycle();
        check("prio_irq1", {31'b0, obs_irq}, 32'd1);
        rd_reg(8);
        check("prio_cause1", obs_rdata, 32'h8000_0001);
        nop(1'b1);
        nop(1'b0);
        nop(1'b0);
        take_cycle();
        check("prio_irq2", {31'b0, obs_irq}, 32'd1);
        rd_reg(8);
        check("prio_cause2", obs_rdata, 32'h8000_0003);
        nop(1'b1);
        nop(1'b0);

        // Kernel blocking
        pulse(4'b0001, 1'b1);
        nop(1'b1);
        nop(1'b1);
        check("kblock_irq", {31'b0, obs_irq}, 32'd0);
        nop(1'b0);
        nop(1'b0);
        check("kblock_release", {31'b0, obs_irq}, 32'd1);
        take_cycle();
        nop(1'b1);
        nop(1'b0);

        // Mask before take
        pulse(4'b0010, 1'b0);
        nop(1'b0);
        wr_reg(0, 32'h0);
        check("mask_irq_before", {31'b0, obs_irq}, 32'd1);
        nop(1'b0);
        check("mask_irq_after", {31'b0, obs_irq}, 32'd0);
        rd_reg(4);
        check("mask_pend_kept", obs_rdata, 32'h2);
        wr_reg(4, 32'h2);
        wr_reg(0, 32'hF);

        // W1C racing a new edge on the same source
        cycle(4'b0001, 1'b0, 1'b0, BASE + 32'd4, 32'h1, 1'b0, 1'b1);
        rd_reg(4);
        check("w1c_race", obs_rdata & 32'h1, 32'h1);
        take_cycle();
        nop(1'b1);
        nop(1'b0);

        // Reset while the handler is running
        pulse(4'b0100, 1'b0);
        nop(1'b0);
        take_cycle();
        nop(1'b1);
        @(negedge clk);
        reset = 1'b1; src_irq = 0; ker = 0; irq_take = 0; mem_read = 0; mem_write = 0;
        #1;
        check("midrst_irq", {31'b0, IRQ}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rd_reg(4 * r);
            check("midrst_reg", obs_rdata, 32'd0);
        end
        pulse(4'b0100, 1'b0);
        nop(1'b0);
        check("midrst_no_irq", {31'b0, obs_irq}, 32'd0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 15));
            cycle(4'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
